// File: rtl/add32_seq_ctrl.sv
// Two-step sequential adder: low half then high half, carry held between steps.
// Valid/ready handshake on both operand input and result output.
module add32_seq_ctrl #(
   parameter int n = 32,
   parameter int m = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         cin,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] s,
   output logic         cout
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]   state;
   logic [1:0]   nxt;
   logic [n-1:0] a_r;
   logic [n-1:0] b_r;
   logic         cin_r;
   logic         hc;
   logic         accept;
   logic [m:0]   lo_sum;
   logic [n-m:0] hi_sum;

   assign accept = in_valid && in_ready;

   // Operands are only taken when idle or when the result leaves this cycle.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   // Next-state: LO and HI always advance; DONE waits for the consumer.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = accept ? LO : IDLE;
         LO:      nxt = HI;
         HI:      nxt = DONE;
         DONE: begin
            if (out_ready)
               nxt = in_valid ? LO : IDLE;
            else
               nxt = DONE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Half-width sums from the captured operands.
   always_comb begin
      lo_sum = {1'b0, a_r[m-1:0]} + {1'b0, b_r[m-1:0]}
             + {{m{1'b0}}, cin_r};
      hi_sum = {1'b0, a_r[n-1:m]} + {1'b0, b_r[n-1:m]}
             + {{(n-m){1'b0}}, hc};
   end

   // State register and result-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         state     <= nxt;
         out_valid <= (nxt == DONE);
      end
   end

   // Capture operands at accept so later input changes cannot disturb them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         cin_r <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b;
         cin_r <= cin;
      end
   end

   // Low half and inter-half carry in LO, high half and carry-out in HI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s    <= '0;
         hc   <= 1'b0;
         cout <= 1'b0;
      end else if (state == LO) begin
         s[m-1:0] <= lo_sum[m-1:0];
         hc       <= lo_sum[m];
      end else if (state == HI) begin
         s[n-1:m] <= hi_sum[n-m-1:0];
         cout     <= hi_sum[n-m];
      end
   end

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Directed and randomised bench for add32_seq_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_add32_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        cin = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] s;
   logic        cout;

   int n_checks = 0;
   int n_fail = 0;

   add32_seq_ctrl #(.n(32), .m(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .cin(cin),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s(s),
      .cout(cout)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck design still ends the run.
   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge; waits at most 10 cycles for out_valid.
   task automatic wait_valid(output int lat, output bit ok);
      lat = 0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   // Called at a falling edge. Offers one operation, scrambles inputs after
   // accept, stalls the consumer, then takes the result.
   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                         input logic xc, input int stall,
                         output logic [31:0] rs, output logic rc,
                         output int lat, output bit ok, output bit stable);
      a = xa;
      b = xb;
      cin = xc;
      in_valid = 1'b1;
      out_ready = 1'b0;
      ok = 1'b0;
      stable = 1'b1;
      lat = 0;
      rs = '0;
      rc = 1'b0;
      for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~xa;
      b = xb ^ 32'h5a5a_5a5a;
      cin = ~xc;
      wait_valid(lat, ok);
      if (!ok) return;
      rs = s;
      rc = cout;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || s !== rs || cout !== rc) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (s !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_s: got %h expected 00000000", s);
      end
      n_checks++;
      if (cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cout: got %b expected 0", cout);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_carry_cross();
      logic [31:0] rs;
      logic rc;
      int lat;
      bit ok;
      bit st;
      run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, rs, rc, lat, ok, st);
      n_checks++;
      if (!ok || rs !== 32'h0001_0000) begin
         n_fail++;
         $display("FAIL carry_cross_s: got %h ok=%0d expected 00010000",
                  rs, ok);
      end
      n_checks++;
      if (rc !== 1'b0) begin
         n_fail++;
         $display("FAIL carry_cross_cout: got %b expected 0", rc);
      end
      n_checks++;
      if (lat != 2) begin
         n_fail++;
         $display("FAIL carry_cross_latency: got %0d expected 2", lat);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL carry_cross_drop: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_corners();
      logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_0000};
      logic [31:0] vb [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_FFFF};
      logic        vc [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] es [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
      logic        ec [3] = '{1'b1, 1'b1, 1'b0};
      logic [31:0] rs;
      logic rc;
      int lat;
      bit ok;
      bit st;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vc[i], 1, rs, rc, lat, ok, st);
         n_checks++;
         if (!ok || rs !== es[i] || rc !== ec[i]) begin
            n_fail++;
            $display("FAIL corner%0d: got %b_%h ok=%0d expected %b_%h",
                     i, rc, rs, ok, ec[i], es[i]);
         end
         n_checks++;
         if (lat != 2 || !st) begin
            n_fail++;
            $display("FAIL corner%0d_timing: lat %0d stable %0d expected 2 1",
                     i, lat, st);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit ok;
      a = 32'h1234_0000;
      b = 32'h0000_5678;
      cin = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 32'h0000_000A;
      b = 32'h0000_0005;
      cin = 1'b0;
      wait_valid(lat, ok);
      n_checks++;
      if (!ok || lat != 2) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d ok=%0d expected 2", lat, ok);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             s !== 32'h1234_5679 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got v=%b r=%b %b_%h expected 1 0 0_12345679",
                     i, out_valid, in_ready, cout, s);
         end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready_follow: got %b expected 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_taken: got %b expected 0", out_valid);
      end
      wait_valid(lat, ok);
      n_checks++;
      if (!ok || lat != 2 || s !== 32'h0000_000F || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_next: got %b_%h lat %0d expected 0_0000000F lat 2",
                  cout, s, lat);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] oa [3] = '{32'd1, 32'd3, 32'd5};
      logic [31:0] ob [3] = '{32'd2, 32'd4, 32'd6};
      logic [31:0] ex [3] = '{32'd3, 32'd7, 32'd11};
      logic [31:0] got [3];
      int when [3];
      int nres = 0;
      int idx = 0;
      bit acc;
      a = oa[0];
      b = ob[0];
      cin = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         acc = in_valid && in_ready;
         @(posedge clk);
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < 3) begin
               a = oa[idx];
               b = ob[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            if (nres < 3) begin
               got[nres] = s;
               when[nres] = cyc;
            end
            nres++;
         end
      end
      out_ready = 1'b0;
      n_checks++;
      if (nres != 3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d expected 3", nres);
      end
      for (int i = 0; i < 3 && i < nres; i++) begin
         n_checks++;
         if (got[i] !== ex[i]) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got %0d expected %0d",
                     i, got[i], ex[i]);
         end
      end
      for (int i = 1; i < 3 && i < nres; i++) begin
         n_checks++;
         if (when[i] - when[i-1] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing%0d: got %0d expected 3",
                     i, when[i] - when[i-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rs;
      logic rc;
      int lat;
      bit ok;
      bit st;
      bit seen = 1'b0;
      a = 32'h1234_5678;
      b = 32'h1111_1111;
      cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || s !== 32'h0 || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got v=%b %b_%h expected 0 0_00000000",
                  out_valid, cout, s);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_ready: got %b expected 1", in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL rst_mid_stale: got result after reset expected none");
      end
      run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, rs, rc, lat, ok, st);
      n_checks++;
      if (!ok || rs !== 32'h0000_0030 || rc !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_next: got %b_%h ok=%0d expected 0_00000030",
                  rc, rs, ok);
      end
   endtask

   task automatic test_random();
      logic [31:0] ra;
      logic [31:0] rb;
      logic rcin;
      logic [32:0] exp;
      logic [31:0] rs;
      logic rc;
      int lat;
      bit ok;
      bit st;
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rcin = 1'($urandom_range(0, 1));
         exp = {1'b0, ra} + {1'b0, rb} + {32'h0, rcin};
         run_op(ra, rb, rcin, $urandom_range(0, 2), rs, rc, lat, ok, st);
         n_checks++;
         if (!ok || !st || lat != 2 || out_valid !== 1'b0 ||
             {rc, rs} !== exp) begin
            n_fail++;
            $display("FAIL random%0d: got %h ok=%0d st=%0d lat=%0d v=%b expected %h",
                     i, {rc, rs}, ok, st, lat, out_valid, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_carry_cross();
      test_corners();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
